wb_regfile: RTL and testbench

- Write-back stage plus architectural register file for the 5-stage RISC-V pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the write-back value (memory data or ALU result).
- Commits that value to a 32x32 register file and serves the two ID-stage read ports.
- Provides write-first bypass, an x0 hardwire, a forwarding tap for the hazard/forwarding unit, and a committed-write counter.

---
 rtl/wb_regfile_if.sv | 32 +++
 rtl/wb_regfile.sv | 53 +++++
 tb/tb_wb_regfile.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, ID read ports, forwarding tap and commit counter.
// The slave side is the register file; the master side is the pipeline that drives it.
interface wb_regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic            RegWrite_i;
    logic            MemtoReg_i;
    logic [XLEN-1:0] ALUResult_i;
    logic [XLEN-1:0] RDdata_i;
    logic [AW-1:0]   RDaddr_i;
    logic [AW-1:0]   RS1addr_i;
    logic [AW-1:0]   RS2addr_i;
    logic [XLEN-1:0] RS1data_o;
    logic [XLEN-1:0] RS2data_o;
    logic [XLEN-1:0] WBdata_o;
    logic            WBvalid_o;
    logic [CNTW-1:0] WBcount_o;

    modport slave (
        input  RegWrite_i, MemtoReg_i, ALUResult_i, RDdata_i, RDaddr_i, RS1addr_i, RS2addr_i,
        output RS1data_o, RS2data_o, WBdata_o, WBvalid_o, WBcount_o
    );

    modport master (
        output RegWrite_i, MemtoReg_i, ALUResult_i, RDdata_i, RDaddr_i, RS1addr_i, RS2addr_i,
        input  RS1data_o, RS2data_o, WBdata_o, WBvalid_o, WBcount_o
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry architectural register file with write-first bypass,
// hardwired x0, forwarding tap and a wrapping committed-write counter.
module wb_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_regfile_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] wb_data_c;
    logic            wb_valid_c;

    always_comb begin
        wb_data_c  = bus.MemtoReg_i ? bus.RDdata_i : bus.ALUResult_i;
        wb_valid_c = bus.RegWrite_i && (bus.RDaddr_i != '0);
    end

    // Bypass is gated by reset so a flushed write never leaks into ID.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] data;
        data = regs_q[addr];
        if (addr == '0)
            data = '0;
        else if (wb_valid_c && !rst_i && (addr == bus.RDaddr_i))
            data = wb_data_c;
        return data;
    endfunction

    always_comb begin
        bus.WBdata_o  = wb_data_c;
        bus.WBvalid_o = wb_valid_c;
        bus.WBcount_o = cnt_q;
        bus.RS1data_o = read_port(bus.RS1addr_i);
        bus.RS2data_o = read_port(bus.RS2addr_i);
    end

    // Commit; entry 0 is only ever cleared, never written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
            cnt_q <= '0;
        end else if (wb_valid_c) begin
            regs_q[bus.RDaddr_i] <= wb_data_c;
            cnt_q                <= cnt_q + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven vectors through a scoreboard queue,
// plus hand-written reset sweep and counter-wrap sequences (counter narrowed to 4 bits).
module tb_wb_regfile;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned CNTW = 4;

    typedef struct {
        logic            rst;
        logic            we;
        logic            m2r;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdd;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] e_rs1;
        logic [XLEN-1:0] e_rs2;
        logic [XLEN-1:0] e_wbd;
        logic            e_wbv;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] wbd;
        logic            wbv;
        logic [CNTW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    vec_t tbl[12];

    wb_regfile_if #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) bus ();

    wb_regfile #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic m2r,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdd,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        rst             = r;
        bus.RegWrite_i  = we;
        bus.MemtoReg_i  = m2r;
        bus.ALUResult_i = alu;
        bus.RDdata_i    = rdd;
        bus.RDaddr_i    = rd;
        bus.RS1addr_i   = rs1;
        bus.RS2addr_i   = rs2;
    endtask

    // Drive one cycle of stimulus after the edge, queue its expectation, compare at negedge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        drive(v.rst, v.we, v.m2r, v.alu, v.rdd, v.rd, v.rs1, v.rs2);
        e.rs1 = v.e_rs1; e.rs2 = v.e_rs2; e.wbd = v.e_wbd; e.wbv = v.e_wbv; e.cnt = v.e_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard: queue empty", tag);
        end else begin
            got = sb_q.pop_front();
            chk({tag, " rs1"}, bus.RS1data_o, got.rs1);
            chk({tag, " rs2"}, bus.RS2data_o, got.rs2);
            chk({tag, " wbdata"}, bus.WBdata_o, got.wbd);
            chk({tag, " wbvalid"}, XLEN'(bus.WBvalid_o), XLEN'(got.wbv));
            chk({tag, " wbcount"}, XLEN'(bus.WBcount_o), XLEN'(got.cnt));
        end
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic m2r,
                                input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdd,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                                input logic [XLEN-1:0] ew, input logic ev, input logic [CNTW-1:0] ec);
        vec_t v;
        v.rst = r; v.we = we; v.m2r = m2r; v.alu = alu; v.rdd = rdd;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_wbd = ew; v.e_wbv = ev; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [CNTW-1:0] exp_cnt;
        checks   = 0;
        failures = 0;

        //            rst we m2r alu           rdd           rd  rs1 rs2  e_rs1         e_rs2         e_wbd         wbv cnt
        tbl[0]  = mk(0, 1, 0, 32'h0000_00AB, 32'hFFFF_FFFF, 5,  5,  0,  32'h0000_00AB, 32'h0,        32'h0000_00AB, 1, 0);
        tbl[1]  = mk(0, 0, 1, 32'h0,         32'h0,         5,  5,  5,  32'h0000_00AB, 32'h0000_00AB, 32'h0,        0, 1);
        tbl[2]  = mk(0, 1, 1, 32'h0000_1111, 32'hDEAD_BEEF, 7,  7,  7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1);
        tbl[3]  = mk(0, 0, 0, 32'h0,         32'h0,         0,  7,  5,  32'hDEAD_BEEF, 32'h0000_00AB, 32'h0,        0, 2);
        tbl[4]  = mk(0, 1, 0, 32'h0000_1234, 32'h0,         0,  0,  7,  32'h0,         32'hDEAD_BEEF, 32'h0000_1234, 0, 2);
        tbl[5]  = mk(0, 0, 0, 32'h0,         32'h0,         0,  0,  0,  32'h0,         32'h0,         32'h0,        0, 2);
        tbl[6]  = mk(0, 1, 0, 32'h0000_0055, 32'h0,         3,  3,  4,  32'h0000_0055, 32'h0,         32'h0000_0055, 1, 2);
        tbl[7]  = mk(1, 1, 0, 32'h0000_0099, 32'h0,         3,  3,  5,  32'h0000_0055, 32'h0000_00AB, 32'h0000_0099, 1, 3);
        tbl[8]  = mk(0, 0, 0, 32'h0,         32'h0,         0,  3,  5,  32'h0,         32'h0,         32'h0,        0, 0);
        tbl[9]  = mk(0, 1, 0, 32'h0000_A5A5, 32'h0,         31, 31, 30, 32'h0000_A5A5, 32'h0,         32'h0000_A5A5, 1, 0);
        tbl[10] = mk(0, 1, 1, 32'h0,         32'h0000_CAFE, 31, 31, 31, 32'h0000_CAFE, 32'h0000_CAFE, 32'h0000_CAFE, 1, 1);
        tbl[11] = mk(0, 0, 0, 32'h0,         32'h0,         0,  31, 0,  32'h0000_CAFE, 32'h0,         32'h0,        0, 2);

        // Initial reset, with a write presented that must be dropped.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd9, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Every register reads zero on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            bus.RS1addr_i = 5'(i);
            bus.RS2addr_i = 5'(31 - i);
            #1;
            chk($sformatf("reset rs1[%0d]", i), bus.RS1data_o, 32'h0);
            chk($sformatf("reset rs2[%0d]", 31 - i), bus.RS2data_o, 32'h0);
        end
        chk("reset wbcount", XLEN'(bus.WBcount_o), 32'h0);

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Counter wrap: from 2, thirteen writes reach 15, the next wraps to 0.
        exp_cnt = CNTW'(2);
        for (int k = 1; k <= 14; k++) begin
            v = mk(0, 1, 0, XLEN'(k), 32'h0, 5'd1, 5'd1, 5'd2,
                   XLEN'(k), 32'h0, XLEN'(k), 1'b1, exp_cnt);
            apply(v, $sformatf("wrap%0d", k));
            exp_cnt = exp_cnt + CNTW'(1);
        end
        v = mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd0, 32'h0000_000E, 32'h0, 32'h0, 1'b0, 4'h0);
        apply(v, "wrapped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
